// File: rtl/data_unpacker.sv
// Width down-converter: splits each IN_WIDTH word into NUM_SLICES OUT_WIDTH words, LSB slice first.
// Define DATA_UNPACKER_LAST_EN to add the registered m_write_last output.
module data_unpacker #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int OP_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_write_req,
    output logic                 s_write_ready,
    input  logic [IN_WIDTH-1:0]  s_write_data,
    output logic                 m_write_req,
    input  logic                 m_write_ready,
    output logic [OUT_WIDTH-1:0] m_write_data
`ifdef DATA_UNPACKER_LAST_EN
    ,
    output logic                 m_write_last
`endif
);
    localparam int NUM_SLICES = (IN_WIDTH <= OUT_WIDTH) ? 1 : IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W      = $clog2(NUM_SLICES) + 1;
    localparam int BUF_W      = NUM_SLICES * OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    if ((IN_WIDTH > OUT_WIDTH) && (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_in_width
        $error("data_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (OUT_WIDTH % OP_WIDTH != 0) begin : g_bad_op_width
        $error("data_unpacker: OUT_WIDTH must be a multiple of OP_WIDTH");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   load_word;
    logic               at_last;
    logic               s_acc;
    logic               m_acc;

    // Narrower inputs are zero-extended so the single slice is the whole output word.
    assign load_word = BUF_W'(s_write_data);
    assign at_last   = (cnt_q == LAST_IDX);

    // Combinational on m_write_ready so a new word lands in the same cycle the last slice leaves.
    assign s_write_ready = !reset && ((state_q == EMPTY) || (at_last && m_write_ready));
    assign s_acc         = s_write_req && s_write_ready;
    assign m_acc         = m_write_req && m_write_ready;

    assign m_write_req  = (state_q == DRAIN);
    assign m_write_data = buf_q[OUT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (s_acc) begin
                    buf_d   = load_word;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_acc) begin
                    if (!at_last) begin
                        buf_d = buf_q >> OUT_WIDTH;
                        cnt_d = cnt_q + 1'b1;
                    end else if (s_acc) begin
                        buf_d = load_word;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DATA_UNPACKER_LAST_EN
    logic last_q, last_d;

    assign last_d       = (state_d == DRAIN) && (cnt_d == LAST_IDX);
    assign m_write_last = last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule
